rv32_mul_unit: RTL and testbench

- Pipelined RV32M multiply execute unit: accepts MUL/MULH/MULHSU/MULHU operations over a valid/ready handshake and returns the 32-bit result 3 cycles later.
- Sits in the execute stage, downstream of decode/issue and directly upstream of writeback.
- Converts operands to magnitude, feeds a 32x32 unsigned Vedic multiplier tree (built from the 2-bit Vedic multiplier cells), then restores sign and selects the low or high word.

---
 rtl/rv32_mul_unit.sv | 162 ++++++++++++++++
 tb/tb_rv32_mul_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_mul_unit.sv
// ---------------------------------------------------------------------------
// rv32_mul_unit -- three-stage RV32M multiply execute unit.
//
// Accepts MUL / MULH / MULHSU / MULHU over a valid/ready handshake and
// returns the 32-bit result three cycles after the input transfer.
//   S1: operand conditioning (magnitudes, negate flag, op, tag)
//   S2: 64-bit unsigned product from a 2-bit Vedic multiplier tree
//   S3: sign restore and low/high word select into the out_* registers
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   flush             kills every in-flight operation (and any offered op)
//   in_valid/in_ready input handshake; in_ready = advance
//   in_op             00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   in_rs1/in_rs2     operands
//   in_tag            pass-through tag
//   out_valid/out_ready output handshake
//   out_result/out_tag result word and its tag
// ---------------------------------------------------------------------------

// 2x2 Vedic (Urdhva-Tiryakbhyam) multiplier cell.
module rv32_vedic2x2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);
    logic cross_lo;
    logic cross_hi;
    logic top;
    logic carry1;

    assign p[0]     = a[0] & b[0];
    assign cross_lo = a[1] & b[0];
    assign cross_hi = a[0] & b[1];
    assign p[1]     = cross_lo ^ cross_hi;
    assign carry1   = cross_lo & cross_hi;
    assign top      = a[1] & b[1];
    assign p[2]     = top ^ carry1;
    assign p[3]     = top & carry1;
endmodule

module rv32_mul_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);
    localparam int DIGITS = XLEN / 2;   // 2-bit digits per operand
    localparam int PW     = 2 * XLEN;   // full product width

    logic advance;

    // Stage registers
    logic             s1_valid, s2_valid, s3_valid;
    logic [XLEN-1:0]  s1_a_mag, s1_b_mag;
    logic             s1_neg, s2_neg;
    logic [1:0]       s1_op, s2_op;
    logic [TAG_W-1:0] s1_tag, s2_tag;
    logic [PW-1:0]    s2_prod;

    // Combinational per-stage values
    logic             sign_a, sign_b;
    logic [XLEN-1:0]  a_mag_next, b_mag_next;
    logic [PW-1:0]    tree_prod;
    logic [PW-1:0]    signed_prod;
    logic [XLEN-1:0]  result_next;

    // A stalled output freezes the whole pipe; bubbles are kept in place.
    assign advance   = !s3_valid || out_ready;
    assign in_ready  = advance;
    assign out_valid = s3_valid;

    // ---------------- S1: operand conditioning ----------------
    // rs1 is signed for MULH and MULHSU, rs2 only for MULH.
    assign sign_a = (in_op == 2'b01 || in_op == 2'b10) ? in_rs1[XLEN-1] : 1'b0;
    assign sign_b = (in_op == 2'b01) ? in_rs2[XLEN-1] : 1'b0;
    // The most negative value maps to itself, which is its correct
    // unsigned magnitude.
    assign a_mag_next = sign_a ? (~in_rs1 + 1'b1) : in_rs1;
    assign b_mag_next = sign_b ? (~in_rs2 + 1'b1) : in_rs2;

    // ---------------- S2: Vedic multiplier tree ----------------
    // Every digit pair of the magnitudes gets a 2x2 cell; the 4-bit
    // partial product of digits (i, j) carries weight 4^(i+j).
    logic [3:0] pp [DIGITS][DIGITS];

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_row
            for (genvar gj = 0; gj < DIGITS; gj++) begin : g_col
                rv32_vedic2x2 u_cell (
                    .a (s1_a_mag[2*gi +: 2]),
                    .b (s1_b_mag[2*gj +: 2]),
                    .p (pp[gi][gj])
                );
            end
        end
    endgenerate

    always_comb begin
        tree_prod = '0;
        for (int i = 0; i < DIGITS; i++) begin
            for (int j = 0; j < DIGITS; j++) begin
                tree_prod = tree_prod + (PW'(pp[i][j]) << (2 * (i + j)));
            end
        end
    end

    // ---------------- S3: sign restore and word select ----------------
    assign signed_prod = s2_neg ? (~s2_prod + 1'b1) : s2_prod;
    assign result_next = (s2_op == 2'b00) ? signed_prod[XLEN-1:0]
                                          : signed_prod[PW-1:XLEN];

    // ---------------- Pipeline registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            s3_valid   <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
        end else begin
            if (flush) begin
                // Also drops whatever is offered this cycle.
                s1_valid <= 1'b0;
                s2_valid <= 1'b0;
                s3_valid <= 1'b0;
            end else if (advance) begin
                s1_valid <= in_valid;
                s2_valid <= s1_valid;
                s3_valid <= s2_valid;
            end

            if (advance) begin
                s1_a_mag   <= a_mag_next;
                s1_b_mag   <= b_mag_next;
                s1_neg     <= sign_a ^ sign_b;
                s1_op      <= in_op;
                s1_tag     <= in_tag;

                s2_prod    <= tree_prod;
                s2_neg     <= s1_neg;
                s2_op      <= s1_op;
                s2_tag     <= s1_tag;

                out_result <= result_next;
                out_tag    <= s2_tag;
            end
        end
    end
endmodule

// File: tb/tb_rv32_mul_unit.sv
// ---------------------------------------------------------------------------
// tb_rv32_mul_unit -- self-checking bench for rv32_mul_unit.
// Directed cases (reset, sign/boundary values, stall, flush) followed by
// randomized traffic checked against a 64-bit arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_rv32_mul_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_tag;

    rv32_mul_unit #(.XLEN(32), .TAG_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [31:0] exp_next;
    logic        accepted;
    logic        lat_check = 1'b0;
    logic        hold_pend = 1'b0;
    logic        post_flush = 1'b0;
    logic [31:0] held_res;
    logic [4:0]  held_tag;

    // RV32M reference: full-precision products in 64-bit arithmetic.
    function automatic logic [31:0] ref_mul(input logic [1:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb_v, ua, ub, p;
        sa   = longint'($signed(a));
        sb_v = longint'($signed(b));
        ua   = longint'({32'b0, a});
        ub   = longint'({32'b0, b});
        case (op)
            2'b00:   p = ua * ub;
            2'b01:   p = sa * sb_v;
            2'b10:   p = sa * ub;
            default: p = ua * ub;
        endcase
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, expv);
        end
    endtask

    // One clock cycle: sample outputs at the falling edge, score them,
    // record an accepted input, then move to just after the next rising edge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (hold_pend) begin
            chk("hold_valid", {31'b0, out_valid}, 32'd1);
            chk("hold_result", out_result, held_res);
            chk("hold_tag", {27'b0, out_tag}, {27'b0, held_tag});
        end
        if (post_flush)
            chk("post_flush_valid", {31'b0, out_valid}, 32'd0);
        chk("in_ready", {31'b0, in_ready}, {31'b0, (!out_valid || out_ready)});
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_output", {31'b0, out_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("result", out_result, e.res);
                chk("tag", {27'b0, out_tag}, {27'b0, e.tag});
                if (lat_check)
                    chk("latency", 32'(cyc - e.cyc), 32'd3);
            end
        end
        hold_pend  = out_valid && !out_ready && !flush;
        held_res   = out_result;
        held_tag   = out_tag;
        post_flush = flush;
        accepted   = 1'b0;
        if (flush) begin
            sb.delete();
        end else if (in_valid && in_ready) begin
            sb.push_back('{exp_next, in_tag, cyc});
            accepted = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag,
                         input logic [31:0] expv);
        int wait_cnt;
        in_valid = 1'b1;
        in_op    = op;
        in_rs1   = a;
        in_rs2   = b;
        in_tag   = tag;
        exp_next = expv;
        wait_cnt = 0;
        do begin
            step();
            wait_cnt++;
        end while (!accepted && wait_cnt < 50);
        if (!accepted)
            chk("accept_timeout", 32'(wait_cnt), 32'd0);
        in_valid = 1'b0;
    endtask

    task automatic drain(input int bound);
        int n;
        out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < bound) begin
            step();
            n++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
        // Idle cycles so any duplicated result shows up as spurious.
        repeat (3) step();
    endtask

    initial begin
        int k;
        int c;
        int ops;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_rs1    = '0;
        in_rs2    = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        exp_next  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state, first cycle after reset
        @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_tag", {27'b0, out_tag}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Basic MUL with exact latency
        lat_check = 1'b1;
        issue(2'b00, 32'd7, 32'd6, 5'd3, 32'h0000_002A);
        drain(20);

        // Sign and boundary cases
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'h0000_0000);
        issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFE);
        issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFF);
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h0000_0001);
        issue(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd8, 32'h4000_0000);
        issue(2'b00, 32'h8000_0000, 32'h8000_0000, 5'd9, 32'h0000_0000);
        drain(20);

        // Back-to-back with a two-cycle output stall starting at cycle 3
        lat_check = 1'b0;
        k = 0;
        c = 0;
        while (k < 4 && c < 30) begin
            in_valid  = 1'b1;
            in_op     = 2'(k);
            in_rs1    = 32'h1000_0001 * (k + 3);
            in_rs2    = 32'hF000_0005 - k;
            in_tag    = 5'(10 + k);
            exp_next  = ref_mul(in_op, in_rs1, in_rs2);
            out_ready = !(c == 3 || c == 4);
            step();
            if (accepted) k++;
            c++;
        end
        chk("stall_all_issued", 32'(k), 32'd4);
        in_valid = 1'b0;
        drain(30);

        // Flush with the pipe full and a new op offered in the same cycle
        lat_check = 1'b0;
        issue(2'b00, 32'd11, 32'd12, 5'd20, 32'd132);
        issue(2'b11, 32'd13, 32'd14, 5'd21, 32'd0);
        issue(2'b01, 32'd15, 32'd16, 5'd22, 32'd0);
        out_ready = 1'b0;
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_op     = 2'b00;
        in_rs1    = 32'd17;
        in_rs2    = 32'd18;
        in_tag    = 5'd23;
        exp_next  = 32'd306;
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) step();
        chk("flush_queue_empty", 32'(sb.size()), 32'd0);
        lat_check = 1'b1;
        issue(2'b00, 32'd100, 32'd200, 5'd24, 32'd20000);
        drain(20);

        // Randomized traffic against the reference model
        lat_check = 1'b0;
        ops = 0;
        c   = 0;
        while (ops < 10000 && c < 60000) begin
            if (!in_valid && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_op    = 2'($urandom_range(0, 3));
                in_rs1   = rnd_opnd();
                in_rs2   = rnd_opnd();
                in_tag   = 5'($urandom);
                exp_next = ref_mul(in_op, in_rs1, in_rs2);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            step();
            if (accepted) begin
                in_valid = 1'b0;
                ops++;
            end
            c++;
        end
        chk("random_ops_issued", 32'(ops), 32'd10000);
        in_valid = 1'b0;
        drain(50);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
